serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Bit-serial 32-bit adder/subtractor built around one `full_adder` instance and a carry flip-flop. It accepts two operands with a start pulse and processes one bit per clock, LSB first. It returns the sum or difference with MIPS-style `carry_out`, `overflow` and `zero` flags. It sits beside the ALU as a low-area arithmetic unit for multi-cycle datapath experiments and for exercising `full_adder` over a full word.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 2.
- `CNT_W`, `$clog2(WIDTH)+1`: bit-counter width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, one clock, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  WIDTH  sum/difference; held until the next accepted start.
- `carry_out`  out  1  carry out of the MSB (for subtract: 1 = no borrow).
- `overflow`  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- `zero`  out  1  `result == 0`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE, `start`=1:**
  - latch `a` into `a_sh`;
  - latch `sub ? ~b : b` into `b_sh`;
  - set carry register to `sub`;
  - clear `cnt` and the result shift register;
  - go to RUN.
- **RUN, each cycle:**
  - `full_adder(sum, cout, a_sh[0], b_sh[0], carry)`;
  - `result <= {sum, result[WIDTH-1:1]}`;
  - `a_sh`/`b_sh` shift right by one;
  - `carry <= cout`;
  - `cnt <= cnt+1`.
- **RUN, when `cnt == WIDTH-1`:**
  - register `carry_out <= cout`;
  - register `overflow <= carry ^ cout`;
  - go to DONE.
- **DONE:**
  - `done`=1;
  - `zero` reflects the final `result`;
  - next state is IDLE, or RUN if `start`=1, which accepts new operands exactly as in IDLE.
- **RUN ignores `start`:** no queuing, no effect on the operation in flight.
- **Flag retention:** `result`, `carry_out`, `overflow` and `zero` hold their values through IDLE until the next accepted start. They are cleared to 0 when that start is accepted.
- **Arithmetic:** modulo 2^WIDTH, with no sign extension.
  - For `sub`=1: `result = a + ~b + 1`.
  - `carry_out` is the raw adder carry.

## Timing
- **Reset (`rst_n`=0 at an edge), in all states including mid-RUN:**
  - state goes to IDLE;
  - `busy`, `done`, `result`, `carry_out`, `overflow`, `zero`, `cnt`, carry and shift registers all become 0;
  - the operation in flight is discarded with no `done`.
- **Latency:** if `start` is sampled at edge E0, `busy` is high after E0 through E_WIDTH. `done` is high in the single cycle between E_WIDTH and E_WIDTH+1, so an operation takes WIDTH+1 cycles start-to-done.
- **Throughput:** `start` held during the DONE cycle gives back-to-back operations every WIDTH+1 cycles. `busy` rises again the cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Operands may change freely after the start edge.

## Structure
- **Package `serial_alu_pkg`:**
  - state enum `{S_IDLE, S_RUN, S_DONE}`, 2 bits;
  - `localparam` `DEFAULT_WIDTH = 32`.
- **Sub-module:** the existing `full_adder`, port order `(sum, carry_out, a, b, carry_in)`, instantiated once as the bit-slice.
- **Remaining logic, all in `serial_add_sub`:**
  - FSM;
  - counter;
  - the three shift registers;
  - carry flip-flop and flag registers.

## Test plan
- **Add:** `a`=5, `b`=3, `sub`=0 → after 33 cycles `done`=1, `result`=0x00000008, `carry_out`=0, `overflow`=0, `zero`=0.
- **Signed overflow:** `a`=0x7FFFFFFF, `b`=1, `sub`=0 → `result`=0x80000000, `overflow`=1, `carry_out`=0. Also 0xFFFFFFFF+1 → `result`=0, `carry_out`=1, `zero`=1, `overflow`=0.
- **Subtract:** 5−7 → `result`=0xFFFFFFFE, `carry_out`=0, `overflow`=0. 9−9 → `result`=0, `zero`=1, `carry_out`=1. 0x80000000−1 → `result`=0x7FFFFFFF, `overflow`=1.
- **Back-to-back, `start` held in DONE:**
  - second operation 1+1;
  - `done` pulses exactly 33 cycles apart;
  - second `result`=2.
- **`start` while busy:** pulse `start` with new operands at RUN cycle 10 → first result unchanged; only one `done`; `busy` pattern unaltered.
- **Reset mid-operation:** assert `rst_n`=0 for one edge at RUN cycle 16 → next cycle all outputs are 0, state is IDLE, and no `done` pulse follows. A new start then completes normally.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial arithmetic unit.
//   state_e       : sequencer states of serial_add_sub
//   DEFAULT_WIDTH : default operand/result width
package serial_alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage : serial_alu_pkg

// File: rtl/full_adder.sv
// One-bit full adder, used as the bit-slice of the serial adder.
//   sum       : a ^ b ^ carry_in
//   carry_out : majority(a, b, carry_in)
//   a, b      : operand bits
//   carry_in  : incoming carry
module full_adder (
    output logic sum,
    output logic carry_out,
    input  logic a,
    input  logic b,
    input  logic carry_in
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule : full_adder

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   start           : request, accepted in IDLE or DONE
//   sub             : 0 = a+b, 1 = a-b (sampled with start)
//   a, b            : operands (sampled with start)
//   busy            : high while the operation is running
//   done            : one-cycle pulse when result/flags are valid
//   result          : sum/difference, held until the next accepted start
//   carry_out       : carry out of the MSB (subtract: 1 = no borrow)
//   overflow        : signed overflow
//   zero            : result == 0
module serial_add_sub
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic               cout_q;
    logic               ovf_q;
    logic               zero_q;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_d;
    logic               last_bit;

    full_adder u_fa (
        .sum       (fa_sum),
        .carry_out (fa_cout),
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .carry_in  (carry_q)
    );

    // Result register after this cycle's bit is shifted in from the top.
    assign res_d    = {fa_sum, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        a_sh_q  <= a;
                        b_sh_q  <= sub ? ~b : b;
                        carry_q <= sub;
                        res_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= fa_cout;
                        ovf_q   <= carry_q ^ fa_cout;
                        zero_q  <= (res_d == '0);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic          zero;

    int checks = 0;
    int errors = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-edge start; returns #1 after the accepting edge E0.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'b0;
    endtask

    // Waits (bounded) for done; cycles = edges after E0, -1 on timeout.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({busy, done, carry_out, overflow, zero} !== 5'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b res=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, carry_out, overflow, zero);
        end
    endtask

    task automatic test_add_sub;
        logic [W-1:0] va  [6] = '{32'd5, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd9, 32'h80000000};
        logic [W-1:0] vb  [6] = '{32'd3, 32'd1,        32'd1,        32'd7, 32'd9, 32'd1};
        logic         vs  [6] = '{1'b0,  1'b0,         1'b0,         1'b1,  1'b1,  1'b1};
        logic [W-1:0] er  [6] = '{32'h8, 32'h80000000, 32'h0, 32'hFFFFFFFE, 32'h0, 32'h7FFFFFFF};
        logic [2:0]   ecvz[6] = '{3'b000, 3'b010,      3'b101,       3'b000, 3'b101, 3'b110};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vs[i]);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || result !== '0) begin
                errors++;
                $display("FAIL start_accept[%0d] busy=%b done=%b res=%h, required 1 0 0", i, busy, done, result);
            end
            wait_done(cyc);
            checks++;
            if (cyc != W) begin
                errors++;
                $display("FAIL latency[%0d] got %0d edges, required %0d", i, cyc, W);
            end
            checks++;
            if (result !== er[i] || {carry_out, overflow, zero} !== ecvz[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL arith[%0d] res=%h cvz=%b busy=%b, required res=%h cvz=%b busy=0",
                         i, result, {carry_out, overflow, zero}, busy, er[i], ecvz[i]);
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || result !== er[i] || {carry_out, overflow, zero} !== ecvz[i]) begin
                errors++;
                $display("FAIL hold[%0d] done=%b res=%h cvz=%b, required done=0 res=%h cvz=%b",
                         i, done, result, {carry_out, overflow, zero}, er[i], ecvz[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(32'd5, 32'd3, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != W || result !== 32'd8) begin
            errors++;
            $display("FAIL b2b_first cyc=%0d res=%h, required cyc=%0d res=00000008", cyc, result, W);
        end
        issue(32'd1, 32'd1, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart busy=%b done=%b, required 1 0", busy, done);
        end
        wait_done(cyc);
        checks++;
        if (cyc != W || result !== 32'd2 || zero !== 1'b0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second cyc=%0d res=%h z=%b c=%b, required cyc=%0d res=00000002 z=0 c=0",
                     cyc, result, zero, carry_out, W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy;
        int done_cnt = 0;
        int done_at  = -1;
        int busy_bad = 0;
        issue(32'h12345678, 32'h11111111, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) begin
                start = 1'b1;
                a     = 32'hFFFFFFFF;
                b     = 32'hFFFFFFFF;
                sub   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (busy !== ((k < int'(W)) ? 1'b1 : 1'b0)) busy_bad++;
        end
        checks++;
        if (done_cnt != 1 || done_at != W) begin
            errors++;
            $display("FAIL busy_start_done count=%0d at=%0d, required 1 at %0d", done_cnt, done_at, W);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_start_pattern bad_cycles=%0d, required 0", busy_bad);
        end
        checks++;
        if (result !== 32'h23456789 || {carry_out, overflow, zero} !== 3'b000) begin
            errors++;
            $display("FAIL busy_start_result res=%h cvz=%b, required 23456789 000",
                     result, {carry_out, overflow, zero});
        end
    endtask

    task automatic test_reset_mid;
        int seen_done = 0;
        int cyc;
        issue(32'h7FFFFFFF, 32'd1, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({busy, done, carry_out, overflow, zero} !== 5'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs busy=%b done=%b res=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, carry_out, overflow, zero);
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet active_cycles=%0d, required 0", seen_done);
        end
        issue(32'd9, 32'd9, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc != W || result !== '0 || {carry_out, overflow, zero} !== 3'b101) begin
            errors++;
            $display("FAIL reset_mid_recover cyc=%0d res=%h cvz=%b, required cyc=%0d res=0 cvz=101",
                     cyc, result, {carry_out, overflow, zero}, W);
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_back_to_back;
        test_start_while_busy;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_sub
